resp_merger: RTL and testbench

RESP_MERGER -- requirements
Module: resp_merger

---
 rtl/resp_merger.sv | 102 ++++++++++
 tb/tb_resp_merger.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/resp_merger.sv
// resp_merger: merges memory and peripheral response streams back into
// request order using a 1-bit order FIFO that records each request's destination.
module resp_merger #(
   parameter int unsigned p_depth = 4,
   parameter int unsigned p_msg_w = 32
) (
   input  logic                       clk,
   input  logic                       rst,

   input  logic                       req_xfer,
   input  logic                       req_dst,
   output logic                       req_ok,

   input  logic                       memory_val,
   output logic                       memory_rdy,
   input  logic [p_msg_w-1:0]         memory_msg,

   input  logic                       peripheral_val,
   output logic                       peripheral_rdy,
   input  logic [p_msg_w-1:0]         peripheral_msg,

   output logic                       resp_val,
   input  logic                       resp_rdy,
   output logic [p_msg_w-1:0]         resp_msg,

   output logic [$clog2(p_depth):0]   outstanding,
   output logic                       ovf
);

   localparam int unsigned PW = $clog2(p_depth);
   localparam int unsigned CW = PW + 1;

   logic [p_depth-1:0] order_q;
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic [CW-1:0]      count;
   logic               ovf_q;

   logic               nonempty;
   logic               head;
   logic               push;
   logic               pop;

   assign nonempty    = (count != '0);
   assign head        = order_q[rd_ptr];
   assign req_ok      = (count < CW'(p_depth));
   assign push        = req_xfer & req_ok;
   assign pop         = resp_val & resp_rdy;
   assign outstanding = count;
   assign ovf         = ovf_q;

   // Route the head-selected source to the core; the other source is held off.
   always_comb begin
      resp_val       = 1'b0;
      resp_msg       = memory_msg;
      memory_rdy     = 1'b0;
      peripheral_rdy = 1'b0;
      if (nonempty) begin
         if (head) begin
            resp_val       = peripheral_val;
            resp_msg       = peripheral_msg;
            peripheral_rdy = resp_rdy;
         end else begin
            resp_val       = memory_val;
            memory_rdy     = resp_rdy;
         end
      end
   end

   // Order FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            count <= count + CW'(1);
         end else if (pop && !push) begin
            count <= count - CW'(1);
         end
         if (req_xfer && !req_ok) begin
            ovf_q <= 1'b1;
         end
      end
   end

   // Destination storage; entries are only meaningful while tracked, so no reset.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         order_q[wr_ptr] <= req_dst;
      end
   end

endmodule

// File: tb/tb_resp_merger.sv
// tb_resp_merger: directed scenarios plus randomized traffic, all checked
// every cycle against a queue-based model of in-order response merging.
module tb_resp_merger;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_xfer;
   logic        req_dst;
   logic        req_ok;
   logic        memory_val;
   logic        memory_rdy;
   logic [31:0] memory_msg;
   logic        peripheral_val;
   logic        peripheral_rdy;
   logic [31:0] peripheral_msg;
   logic        resp_val;
   logic        resp_rdy;
   logic [31:0] resp_msg;
   logic [2:0]  outstanding;
   logic        ovf;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // Model state: destinations of accepted, not yet answered requests.
   bit          mq[$];
   bit          m_ovf  = 1'b0;
   bit          m_live = 1'b0;

   resp_merger #(.p_depth(DEPTH), .p_msg_w(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .req_xfer       (req_xfer),
      .req_dst        (req_dst),
      .req_ok         (req_ok),
      .memory_val     (memory_val),
      .memory_rdy     (memory_rdy),
      .memory_msg     (memory_msg),
      .peripheral_val (peripheral_val),
      .peripheral_rdy (peripheral_rdy),
      .peripheral_msg (peripheral_msg),
      .resp_val       (resp_val),
      .resp_rdy       (resp_rdy),
      .resp_msg       (resp_msg),
      .outstanding    (outstanding),
      .ovf            (ovf)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Compare all outputs against the model for the current inputs, then clock once.
   task automatic cycle();
      bit          e_ok, e_val, e_mrdy, e_prdy;
      logic [31:0] e_msg;
      #1;
      e_ok   = (mq.size() < DEPTH);
      e_val  = 1'b0;
      e_mrdy = 1'b0;
      e_prdy = 1'b0;
      e_msg  = memory_msg;
      if (mq.size() > 0) begin
         if (mq[0]) begin
            e_val  = peripheral_val;
            e_msg  = peripheral_msg;
            e_prdy = resp_rdy;
         end else begin
            e_val  = memory_val;
            e_mrdy = resp_rdy;
         end
      end
      if (m_live) begin
         check_eq("req_ok",         32'(req_ok),         32'(e_ok));
         check_eq("outstanding",    32'(outstanding),    32'(mq.size()));
         check_eq("ovf",            32'(ovf),            32'(m_ovf));
         check_eq("resp_val",       32'(resp_val),       32'(e_val));
         check_eq("resp_msg",       resp_msg,            e_msg);
         check_eq("memory_rdy",     32'(memory_rdy),     32'(e_mrdy));
         check_eq("peripheral_rdy", 32'(peripheral_rdy), 32'(e_prdy));
      end
      @(posedge clk);
      if (rst) begin
         mq.delete();
         m_ovf  = 1'b0;
         m_live = 1'b1;
      end else begin
         if (e_val && resp_rdy) void'(mq.pop_front());
         if (req_xfer) begin
            if (e_ok) mq.push_back(req_dst);
            else m_ovf = 1'b1;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      req_xfer       = 1'b0;
      req_dst        = 1'b0;
      memory_val     = 1'b0;
      peripheral_val = 1'b0;
      resp_rdy       = 1'b0;
   endtask

   task automatic push(input bit dst);
      req_xfer = 1'b1;
      req_dst  = dst;
      cycle();
      req_xfer = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
   endtask

   initial begin
      rst            = 1'b1;
      memory_msg     = 32'h0;
      peripheral_msg = 32'h0;
      idle_inputs();
      @(negedge clk);
      do_reset();
      cycle();

      // Single memory response.
      push(1'b0);
      memory_val = 1'b1; memory_msg = 32'hA0000001; resp_rdy = 1'b1;
      cycle();
      check_eq("m1_popped", 32'(outstanding), 32'd0);
      idle_inputs();
      cycle();

      // Peripheral answers first but must wait behind the memory response.
      push(1'b0);
      push(1'b1);
      peripheral_val = 1'b1; peripheral_msg = 32'hB0000001; resp_rdy = 1'b1;
      cycle();
      cycle();
      memory_val = 1'b1; memory_msg = 32'hA0000002;
      cycle();
      memory_val = 1'b0;
      cycle();
      check_eq("p1_after_m1", 32'(outstanding), 32'd0);
      idle_inputs();
      cycle();

      // Fill, then overflow attempt.
      for (int i = 0; i < 4; i++) push(i[0]);
      check_eq("full_req_ok", 32'(req_ok), 32'd0);
      push(1'b1);
      check_eq("ovf_set", 32'(ovf), 32'd1);
      check_eq("full_count", 32'(outstanding), 32'd4);
      memory_val = 1'b1; peripheral_val = 1'b1; resp_rdy = 1'b1;
      memory_msg = 32'hA0000003; peripheral_msg = 32'hB0000003;
      for (int i = 0; i < 5; i++) cycle();
      idle_inputs();
      do_reset();
      check_eq("ovf_cleared", 32'(ovf), 32'd0);

      // Steady stream at count=1 across pointer wrap.
      push(1'b0);
      memory_val = 1'b1; peripheral_val = 1'b1; resp_rdy = 1'b1;
      for (int i = 0; i < 10; i++) begin
         memory_msg     = 32'hA1000000 + 32'(i);
         peripheral_msg = 32'hB1000000 + 32'(i);
         req_xfer = 1'b1;
         req_dst  = i[0] ? 1'b0 : 1'b1;
         cycle();
      end
      check_eq("stream_count", 32'(outstanding), 32'd1);
      req_xfer = 1'b0;
      cycle();
      idle_inputs();
      cycle();

      // Backpressure from the core holds the head response.
      push(1'b0);
      memory_val = 1'b1; memory_msg = 32'hA2000000; resp_rdy = 1'b0;
      for (int i = 0; i < 3; i++) cycle();
      check_eq("held_count", 32'(outstanding), 32'd1);
      resp_rdy = 1'b1;
      cycle();
      check_eq("single_pop", 32'(outstanding), 32'd0);
      idle_inputs();

      // Reset with three outstanding and memory still presenting.
      push(1'b0); push(1'b1); push(1'b0);
      memory_val = 1'b1;
      do_reset();
      check_eq("rst_outstanding", 32'(outstanding), 32'd0);
      check_eq("rst_mem_rdy",     32'(memory_rdy),  32'd0);
      idle_inputs();
      cycle();

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         rst            = ($urandom_range(0, 199) == 0);
         req_xfer       = (mq.size() < DEPTH) ? ($urandom_range(0, 99) < 45)
                                              : ($urandom_range(0, 99) < 3);
         req_dst        = 1'($urandom_range(0, 1));
         memory_val     = ($urandom_range(0, 99) < 50);
         peripheral_val = ($urandom_range(0, 99) < 50);
         resp_rdy       = ($urandom_range(0, 99) < 70);
         memory_msg     = $urandom;
         peripheral_msg = $urandom;
         cycle();
      end
      rst = 1'b0;
      idle_inputs();
      cycle();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
